// File: rtl/jtag_cmd_pkg.sv
// Shared types, default widths and helper functions for the sysclk-side
// virtual-JTAG command front end (jtag_cmd_sync_decoder).
package jtag_cmd_pkg;

    // Default configuration of the decoder
    localparam int SR_WIDTH_DEF    = 38;
    localparam int IR_WIDTH_DEF    = 2;
    localparam int ACT_BIT_DEF     = 34;
    localparam int SYNC_STAGES_DEF = 2;
    localparam int DEPTH_DEF       = 4;

    // Upper bounds for the width-generic helper functions below
    localparam int SR_MAX = 256;
    localparam int IR_MAX = 8;
    localparam int CH_MAX = 256;

    // Meaning of the action-select payload bit
    typedef enum logic {
        CMD_NO_ACT = 1'b0,
        CMD_ACT    = 1'b1
    } cmd_kind_e;

    // Capture FSM states
    typedef enum logic [1:0] {
        ST_ARMED   = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_HOLD    = 2'd2
    } cap_state_e;

    // One-hot expansion of an IR value; callers truncate to 2**IR_WIDTH bits
    function automatic logic [CH_MAX-1:0] onehot(input logic [IR_MAX-1:0] ir);
        logic [CH_MAX-1:0] res;
        res     = {CH_MAX{1'b0}};
        res[ir] = 1'b1;
        return res;
    endfunction

    // True when the (zero-extended) word, including its parity bit, has even weight
    function automatic logic even_parity_ok(input logic [SR_MAX-1:0] word);
        return ((^word) == 1'b0);
    endfunction

endpackage

// File: rtl/jtag_cmd_fifo.sv
// First-word fall-through command FIFO with registered head, valid and level.
// The head register holds the last popped entry once the FIFO drains.
module jtag_cmd_fifo
    import jtag_cmd_pkg::*;
#(
    parameter int WIDTH = SR_WIDTH_DEF + IR_WIDTH_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic                     valid,
    output logic [WIDTH-1:0]         head,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     drop
);

    localparam int AW    = $clog2(DEPTH);
    localparam int LVL_W = AW + 1;
    localparam logic [AW-1:0]    PTR_ONE = AW'(1);
    localparam logic [LVL_W-1:0] LVL_ONE = LVL_W'(1);
    localparam logic [LVL_W-1:0] LVL_MAX = LVL_W'(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [LVL_W-1:0] level_r;
    logic             valid_r;
    logic [WIDTH-1:0] head_r;

    logic             full_s;
    logic             do_push_s;
    logic             do_pop_s;
    logic [AW-1:0]    wr_nx_s;
    logic [AW-1:0]    rd_nx_s;
    logic [LVL_W-1:0] level_nx_s;
    logic [WIDTH-1:0] head_nx_s;

    // Next-state computation for pointers, occupancy and the registered head
    always_comb begin
        full_s    = (level_r == LVL_MAX);
        do_pop_s  = pop && valid_r;
        do_push_s = push && (!full_s || do_pop_s);
        wr_nx_s   = wr_ptr_r;
        rd_nx_s   = rd_ptr_r;
        if (do_push_s) begin
            wr_nx_s = wr_ptr_r + PTR_ONE;
        end else begin
            wr_nx_s = wr_ptr_r;
        end
        if (do_pop_s) begin
            rd_nx_s = rd_ptr_r + PTR_ONE;
        end else begin
            rd_nx_s = rd_ptr_r;
        end
        case ({do_push_s, do_pop_s})
            2'b10:   level_nx_s = level_r + LVL_ONE;
            2'b01:   level_nx_s = level_r - LVL_ONE;
            default: level_nx_s = level_r;
        endcase
        // The new head may be the word being written this very cycle
        if (level_nx_s == {LVL_W{1'b0}}) begin
            head_nx_s = head_r;
        end else if (do_push_s && (rd_nx_s == wr_ptr_r)) begin
            head_nx_s = wdata;
        end else begin
            head_nx_s = mem_r[rd_nx_s];
        end
    end

    // Storage array and pointer/level/head registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {WIDTH{1'b0}};
            end
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            level_r  <= {LVL_W{1'b0}};
            valid_r  <= 1'b0;
            head_r   <= {WIDTH{1'b0}};
        end else begin
            if (do_push_s) begin
                mem_r[wr_ptr_r] <= wdata;
            end
            wr_ptr_r <= wr_nx_s;
            rd_ptr_r <= rd_nx_s;
            level_r  <= level_nx_s;
            valid_r  <= (level_nx_s != {LVL_W{1'b0}});
            head_r   <= head_nx_s;
        end
    end

    assign valid = valid_r;
    assign head  = head_r;
    assign level = level_r;
    assign drop  = push && full_s && !do_pop_s;

endmodule

// File: rtl/jtag_cmd_sync_decoder.sv
// Sysclk-side virtual-JTAG command front end: synchronises the TCK-domain
// update strobe, captures {ir_in, sr} once per update into a command FIFO
// and decodes each popped command into one-hot action / no-action pulses.
// Optional build macro: JTAG_CMD_PARITY_EN (even parity check on sr MSB).
module jtag_cmd_sync_decoder
    import jtag_cmd_pkg::*;
#(
    parameter int SR_WIDTH    = SR_WIDTH_DEF,
    parameter int IR_WIDTH    = IR_WIDTH_DEF,
    parameter int ACT_BIT     = ACT_BIT_DEF,
    parameter int SYNC_STAGES = SYNC_STAGES_DEF,
    parameter int DEPTH       = DEPTH_DEF
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [SR_WIDTH-1:0]       sr,
    input  logic [IR_WIDTH-1:0]       ir_in,
    input  logic                      vs_udr,
    input  logic                      cmd_ready,
    input  logic                      clr_err,
    output logic                      cmd_valid,
    output logic [SR_WIDTH-1:0]       jdo,
    output logic [IR_WIDTH-1:0]       cmd_ir,
    output logic [2**IR_WIDTH-1:0]    take_action,
    output logic [2**IR_WIDTH-1:0]    take_no_action,
    output logic [$clog2(DEPTH):0]    fifo_level,
    output logic                      overflow,
    output logic                      parity_err
);

    localparam int CH    = 2**IR_WIDTH;
    localparam int ENT_W = SR_WIDTH + IR_WIDTH;

    logic [SYNC_STAGES-1:0]  sync_r;
    logic                    udr_s;
    cap_state_e              state_r;
    logic                    push_r;
    logic [ENT_W-1:0]        cap_r;
    logic                    parity_ok_s;

    logic                    valid_s;
    logic [ENT_W-1:0]        head_s;
    logic                    drop_s;
    logic                    pop_s;
    logic [CH-1:0]           dec_s;
    logic [CH-1:0]           take_action_r;
    logic [CH-1:0]           take_no_action_r;
    logic                    overflow_r;

    // Synchroniser chain bringing the TCK-domain update level into clk
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_r <= {SYNC_STAGES{1'b0}};
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], vs_udr};
        end
    end

    assign udr_s = sync_r[SYNC_STAGES-1];

    // Parity qualification of the captured shift register
    always_comb begin
`ifdef JTAG_CMD_PARITY_EN
        parity_ok_s = even_parity_ok(SR_MAX'(sr));
`else
        parity_ok_s = 1'b1;
`endif
    end

    // Capture FSM: one registered push per synchronised update pulse
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= ST_ARMED;
            push_r  <= 1'b0;
            cap_r   <= {ENT_W{1'b0}};
        end else begin
            push_r <= 1'b0;
            case (state_r)
                ST_ARMED: begin
                    if (udr_s) begin
                        state_r <= ST_CAPTURE;
                        cap_r   <= {ir_in, sr};
                        push_r  <= parity_ok_s;
                    end else begin
                        state_r <= ST_ARMED;
                    end
                end
                ST_CAPTURE: begin
                    state_r <= ST_HOLD;
                end
                ST_HOLD: begin
                    if (!udr_s) begin
                        state_r <= ST_ARMED;
                    end else begin
                        state_r <= ST_HOLD;
                    end
                end
                default: begin
                    state_r <= ST_ARMED;
                end
            endcase
        end
    end

    assign pop_s = valid_s && cmd_ready;

    jtag_cmd_fifo #(
        .WIDTH (ENT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (push_r),
        .wdata   (cap_r),
        .pop     (pop_s),
        .valid   (valid_s),
        .head    (head_s),
        .level   (fifo_level),
        .drop    (drop_s)
    );

    assign cmd_valid = valid_s;
    assign jdo       = head_s[SR_WIDTH-1:0];
    assign cmd_ir    = head_s[ENT_W-1:SR_WIDTH];

    // One-hot channel select for the head command
    always_comb begin
        dec_s = CH'(onehot(IR_MAX'(cmd_ir)));
    end

    // Registered decode: a single-cycle pulse on the channel of each popped command
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            take_action_r    <= {CH{1'b0}};
            take_no_action_r <= {CH{1'b0}};
        end else begin
            take_action_r    <= {CH{1'b0}};
            take_no_action_r <= {CH{1'b0}};
            if (pop_s) begin
                if (cmd_kind_e'(jdo[ACT_BIT]) == CMD_ACT) begin
                    take_action_r <= dec_s;
                end else begin
                    take_no_action_r <= dec_s;
                end
            end
        end
    end

    assign take_action    = take_action_r;
    assign take_no_action = take_no_action_r;

    // Sticky overflow flag; a drop in the same cycle as clr_err keeps it set
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            overflow_r <= 1'b0;
        end else if (drop_s) begin
            overflow_r <= 1'b1;
        end else if (clr_err) begin
            overflow_r <= 1'b0;
        end else begin
            overflow_r <= overflow_r;
        end
    end

    assign overflow = overflow_r;

`ifdef JTAG_CMD_PARITY_EN
    logic parity_err_r;

    // Sticky parity flag, set as the rejected capture leaves CAPTURE
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            parity_err_r <= 1'b0;
        end else if ((state_r == ST_CAPTURE) && !push_r) begin
            parity_err_r <= 1'b1;
        end else if (clr_err) begin
            parity_err_r <= 1'b0;
        end else begin
            parity_err_r <= parity_err_r;
        end
    end

    assign parity_err = parity_err_r;
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_jtag_cmd_sync_decoder.sv
// Randomised self-checking bench for jtag_cmd_sync_decoder against a
// queue-based reference model of the command front end.
module tb_jtag_cmd_sync_decoder;

    localparam int SR  = 38;
    localparam int IR  = 2;
    localparam int ACT = 34;
    localparam int S   = 2;
    localparam int D   = 4;
    localparam int CH  = 4;
    localparam int LW  = 3;
    localparam int EW  = SR + IR;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [SR-1:0] sr;
    logic [IR-1:0] ir_in;
    logic          vs_udr;
    logic          cmd_ready;
    logic          clr_err;
    logic          cmd_valid;
    logic [SR-1:0] jdo;
    logic [IR-1:0] cmd_ir;
    logic [CH-1:0] take_action;
    logic [CH-1:0] take_no_action;
    logic [LW-1:0] fifo_level;
    logic          overflow;
    logic          parity_err;

    jtag_cmd_sync_decoder #(
        .SR_WIDTH    (SR),
        .IR_WIDTH    (IR),
        .ACT_BIT     (ACT),
        .SYNC_STAGES (S),
        .DEPTH       (D)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .sr             (sr),
        .ir_in          (ir_in),
        .vs_udr         (vs_udr),
        .cmd_ready      (cmd_ready),
        .clr_err        (clr_err),
        .cmd_valid      (cmd_valid),
        .jdo            (jdo),
        .cmd_ir         (cmd_ir),
        .take_action    (take_action),
        .take_no_action (take_no_action),
        .fifo_level     (fifo_level),
        .overflow       (overflow),
        .parity_err     (parity_err)
    );

    always #5 clk = ~clk;

    int vectors_applied = 0;
    int miscompares     = 0;

    // reference model state
    logic [EW-1:0] q[$];
    logic [EW-1:0] last_e;
    logic [EW-1:0] pend_e;
    logic          m_ovf;
    logic          m_perr;
    logic [CH-1:0] m_act;
    logic [CH-1:0] m_nact;
    int            edge_cnt;
    int            push_edge;
    logic          prev_v;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors_applied++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        last_e    = '0;
        pend_e    = '0;
        m_ovf     = 1'b0;
        m_perr    = 1'b0;
        m_act     = '0;
        m_nact    = '0;
        push_edge = -1;
        prev_v    = 1'b0;
    endtask

    // Predict the effect of the coming clock edge from the inputs about to be applied
    task automatic model_edge(input logic v, input logic rdy, input logic clr);
        int            k;
        logic          pop_ok;
        logic          push_now;
        logic          full;
        logic          ok;
        logic [EW-1:0] hd;
        logic [CH-1:0] one_v;
        one_v    = 4'b0001;
        k        = edge_cnt + 1;
        pop_ok   = rdy && (q.size() > 0);
        push_now = (k == push_edge);
        if (v && !prev_v) begin
            // the command lands in the FIFO SYNC_STAGES+2 edges after the rise is first seen
            push_edge = k + S + 1;
            pend_e    = {ir_in, sr};
        end
        prev_v = v;
        m_act  = '0;
        m_nact = '0;
        if (pop_ok) begin
            hd = q[0];
            if (hd[ACT]) m_act = one_v << hd[EW-1:SR];
            else         m_nact = one_v << hd[EW-1:SR];
        end
        ok = 1'b1;
`ifdef JTAG_CMD_PARITY_EN
        ok = ((^pend_e[SR-1:0]) == 1'b0);
`endif
        full = (q.size() == D);
        if (push_now && ok && full && !pop_ok) m_ovf = 1'b1;
        else if (clr)                           m_ovf = 1'b0;
        if (push_now && !ok)                    m_perr = 1'b1;
        else if (clr)                           m_perr = 1'b0;
        if (pop_ok) last_e = q.pop_front();
        if (push_now && ok && !(full && !pop_ok)) q.push_back(pend_e);
        edge_cnt = k;
    endtask

    task automatic check_all();
        logic [EW-1:0] h;
        h = (q.size() > 0) ? q[0] : last_e;
        check_val("cmd_valid",      64'(cmd_valid),      64'(q.size() > 0));
        check_val("fifo_level",     64'(fifo_level),     64'(q.size()));
        check_val("jdo",            64'(jdo),            64'(h[SR-1:0]));
        check_val("cmd_ir",         64'(cmd_ir),         64'(h[EW-1:SR]));
        check_val("take_action",    64'(take_action),    64'(m_act));
        check_val("take_no_action", 64'(take_no_action), 64'(m_nact));
        check_val("overflow",       64'(overflow),       64'(m_ovf));
        check_val("parity_err",     64'(parity_err),     64'(m_perr));
    endtask

    // one clock: drive at the falling edge, check at the next falling edge
    task automatic tick(input logic v, input logic rdy, input logic clr);
        vs_udr    = v;
        cmd_ready = rdy;
        clr_err   = clr;
        model_edge(v, rdy, clr);
        @(posedge clk);
        @(negedge clk);
        check_all();
    endtask

    // mode: 0 never ready, 1 always ready, 2 random ready/clr, 3 ready only on the push edge
    task automatic pulse(input logic [SR-1:0] sr_v, input logic [IR-1:0] ir_v,
                         input int hi, input int lo, input int mode);
        logic rdy;
        logic clr;
        sr    = sr_v;
        ir_in = ir_v;
        for (int i = 0; i < hi + lo; i++) begin
            case (mode)
                1:       rdy = 1'b1;
                2:       rdy = 1'($urandom_range(0, 1));
                3:       rdy = ((edge_cnt + 1) == push_edge);
                default: rdy = 1'b0;
            endcase
            clr = (mode == 2) && ($urandom_range(0, 15) == 0);
            tick((i < hi), rdy, clr);
        end
    endtask

    initial begin
        logic [63:0] rv;
        reset_n   = 1'b0;
        sr        = '0;
        ir_in     = '0;
        vs_udr    = 1'b0;
        cmd_ready = 1'b0;
        clr_err   = 1'b0;
        edge_cnt  = 0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        check_all();
        reset_n = 1'b1;

        // basic action command on channel 0, then pop it
        pulse(38'h0400000001, 2'd0, 8, 6, 0);
        tick(1'b1 & 1'b0, 1'b1, 1'b0);
        tick(1'b0, 1'b0, 1'b0);

        // no-action command on channel 3
        pulse(38'h0000000005, 2'd3, 6, 5, 0);
        tick(1'b0, 1'b1, 1'b0);
        tick(1'b0, 1'b0, 1'b0);

        // five updates into a depth-4 FIFO with no consumer, then clear
        for (int i = 0; i < 5; i++) begin
            pulse(38'(64'h0400000010 + 64'(i)), 2'(i), 5, 5, 0);
        end
        tick(1'b0, 1'b0, 1'b1);
        tick(1'b0, 1'b0, 1'b0);

        // FIFO full, consumer pops exactly as the fifth capture pushes
        pulse(38'h0400000020, 2'd2, 6, 5, 3);
        for (int i = 0; i < 6; i++) tick(1'b0, 1'b1, 1'b0);

        // long update level yields a single command
        pulse(38'h0000000040, 2'd1, 50, 5, 0);

        // parity-bit-wrong payload (accepted unless the parity check is built in)
        pulse(38'h0400000003, 2'd1, 6, 5, 0);
        pulse(38'h2400000003, 2'd2, 6, 5, 0);
        for (int i = 0; i < 5; i++) tick(1'b0, 1'b1, 1'b0);
        tick(1'b0, 1'b0, 1'b1);

        // reset asserted while the FSM is in HOLD with queued data
        pulse(38'h0400000080, 2'd1, 6, 5, 0);
        sr    = 38'h0400000081;
        ir_in = 2'd2;
        for (int i = 0; i < S + 4; i++) tick(1'b1, 1'b0, 1'b0);
        reset_n   = 1'b0;
        vs_udr    = 1'b0;
        cmd_ready = 1'b1;
        #1;
        model_reset();
        check_all();
        @(posedge clk);
        @(negedge clk);
        check_all();
        reset_n = 1'b1;
        for (int i = 0; i < 6; i++) tick(1'b0, 1'b1, 1'b0);

        // randomised traffic
        for (int n = 0; n < 40; n++) begin
            rv = {$urandom, $urandom};
            pulse(rv[SR-1:0], 2'($urandom_range(0, 3)),
                  $urandom_range(S + 2, S + 12), $urandom_range(S + 2, S + 6),
                  $urandom_range(0, 3));
        end
        for (int i = 0; i < 8; i++) tick(1'b0, 1'b1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
        $finish;
    end

endmodule

// File: doc/jtag_cmd_sync_decoder.md
Name: jtag_cmd_sync_decoder

Overview:
Parametrised sysclk-side debug command front end for virtual-JTAG debug modules. It synchronises the TCK-domain update strobe into clk and captures the shift register and IR on each update into a DEPTH-entry command FIFO. Each popped command is decoded into one-hot take_action / take_no_action pulses per instruction. It sits between the TCK-domain shift logic and the CPU's on-chip debug, memory and trace units.

Parameters:
SR_WIDTH, 38, shift-register/command payload width (>=4)
IR_WIDTH, 2, virtual IR width; decode fans out to 2**IR_WIDTH channels
ACT_BIT, 34, payload bit selecting action (1) vs no-action (0)
SYNC_STAGES, 2, synchroniser flops for vs_udr (>=2)
DEPTH, 4, command FIFO entries (power of two, >=2)

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
sr  in  SR_WIDTH  TCK-domain shift register; quasi-static while vs_udr high
ir_in  in  IR_WIDTH  TCK-domain IR; quasi-static while vs_udr high
vs_udr  in  1  TCK-domain update-DR level, asynchronous to clk
cmd_ready  in  1  consumer accepts head command
clr_err  in  1  clears sticky error flags
cmd_valid  out  1  FIFO non-empty
jdo  out  SR_WIDTH  payload of head command
cmd_ir  out  IR_WIDTH  IR of head command
take_action  out  2**IR_WIDTH  one-hot pulse, popped command with payload[ACT_BIT]=1
take_no_action  out  2**IR_WIDTH  one-hot pulse, popped command with payload[ACT_BIT]=0
fifo_level  out  $clog2(DEPTH)+1  occupancy
overflow  out  1  sticky: command dropped on full
parity_err  out  1  sticky: parity failure (0 when feature absent)

Behaviour:
- Reset (async assert, sync-deassert assumed upstream): FIFO empty, cmd_valid=0, jdo=0, cmd_ir=0, take_*=0, fifo_level=0, overflow=0, parity_err=0, sync chain=0, FSM=ARMED.
- vs_udr passes through SYNC_STAGES flops to udr_s. Protocol requirement: vs_udr high for at least SYNC_STAGES+2 clk cycles; sr/ir_in stable from vs_udr rise until udr_s falls.
- Capture FSM: ARMED --udr_s=1--> CAPTURE (1 cycle: sample sr, ir_in, issue push) -> HOLD --udr_s=0--> ARMED. Exactly one push per vs_udr pulse. Push is visible at cmd_valid one cycle after CAPTURE. Latency from vs_udr rise to cmd_valid = SYNC_STAGES+2 clk.
- FIFO: first-word fall-through; jdo/cmd_ir show the head entry whenever cmd_valid=1 and hold the last popped value when empty. Pop when cmd_valid&&cmd_ready. cmd_ready while empty is ignored.
- Decode is registered: on a pop in cycle N, take_action[cmd_ir] or take_no_action[cmd_ir] is high in cycle N+1 only. At most one bit across both vectors is high.
- Full: push without a same-cycle pop drops the command and sets overflow. Push and pop together when full: both proceed and level is unchanged. Push and pop together when empty: push only.
- fifo_level tracks occupancy and saturates at DEPTH.
- clr_err clears overflow/parity_err. If a set event coincides with clr_err, the set wins.
- Reset mid-capture or mid-pop discards everything. No pulse is emitted after reset.

Optional Feature:
JTAG_CMD_PARITY_EN: when defined, sr[SR_WIDTH-1] is even parity over sr[SR_WIDTH-2:0]. A failing capture is not pushed and sets parity_err; the FSM still goes to HOLD. When undefined, no check is made, every capture is pushed, and parity_err is tied 0.

Decomposition:
- Package jtag_cmd_pkg: ACT/NO_ACT encodings, default widths, function onehot(ir) returning 2**IR_WIDTH vector, parity function.
- Sub-module jtag_cmd_fifo (DEPTH x (SR_WIDTH+IR_WIDTH), FWFT, level output). Synchroniser and FSM stay in the top.

Test Plan:
- Reset then one vs_udr pulse (8 clk), sr=38'h0400000001, ir=0 -> cmd_valid at SYNC_STAGES+2, jdo=38'h0400000001. Pop gives take_action=4'b0001 for one cycle.
- sr bit34=0, ir=2'd3, pop -> take_no_action=4'b1000, take_action=0, single cycle.
- 5 updates with cmd_ready=0, DEPTH=4 -> fifo_level=4, overflow=1, entries are the first 4 in order. Then clr_err -> overflow=0.
- Full FIFO, cmd_ready=1 during a 5th capture -> no overflow, level stays 4, order preserved.
- vs_udr held high 50 clk -> exactly one push. Assert reset_n low mid-HOLD -> all outputs at reset values, no pulse afterward.
- With JTAG_CMD_PARITY_EN, sr parity bit wrong -> no push, parity_err=1. Correct parity -> push. Without the macro, the same stimulus pushes and parity_err=0.
